// File: rtl/step_rr_sched.sv
// step_rr_sched: round-robin scheduler that issues step bursts to a shared 4-phase step machine
// Define STEP_RR_PRIO0_EN to give requester 0 strict priority over the round-robin pool.
module step_rr_sched #(
   parameter int NREQ = 4,
   parameter int LENW = 4,
   parameter int GAP  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*LENW-1:0] len_in,
   input  logic                 y_in,
   output logic [NREQ-1:0]      grant,
   output logic                 step,
   output logic                 busy,
   output logic [NREQ-1:0]      done,
   output logic [1:0]           phase,
   output logic                 err
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT, DONE} state_t;
   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, pick, idx;
   logic [LENW-1:0] cnt_q, cnt_d, len_w;
   logic [3:0]      gap_q, gap_d;
   logic [1:0]      phase_q, phase_d;
   logic            err_q, err_d;
   logic [NREQ-1:0] win_oh;

   assign len_w  = len_in[win_q*LENW +: LENW];
   assign win_oh = NREQ'(1) << win_q;
   assign busy   = state_q != IDLE;
   assign step   = state_q == STEP;
   assign grant  = busy ? win_oh : '0;
   assign done   = (state_q == DONE) ? win_oh : '0;
   assign phase  = phase_q;
   assign err    = err_q;

   // pick the first requester above ptr, wrapping; lowest offset wins
   always_comb begin
      pick = ptr_q;
      idx  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = PW'((int'(ptr_q) + k) % NREQ);
         if (req[idx]) pick = idx;
      end
`ifdef STEP_RR_PRIO0_EN
      if (req[0]) pick = '0;
`endif
   end

   // burst sequencing: arbitration, length load, stepping and gap timing
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: if (req != '0) begin
            win_d   = pick;
            state_d = LOAD;
         end
         LOAD: begin
            cnt_d = len_w;
            if (len_w == '0) state_d = DONE;
            else state_d = STEP;
         end
         STEP: begin
            cnt_d = (cnt_q != '0) ? cnt_q - LENW'(1) : cnt_q;
            gap_d = 4'(GAP - 1);
            if (cnt_d == '0) state_d = DONE;
            else if (GAP == 0) state_d = STEP;
            else state_d = WAIT;
         end
         WAIT: begin
            gap_d = gap_q - 4'd1;
            if (gap_q == '0) state_d = STEP;
         end
         DONE: begin
`ifdef STEP_RR_PRIO0_EN
            if (win_q != '0) ptr_d = win_q;
`else
            ptr_d = win_q;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // mirror of the stepped machine; a phase-3 hold falls back to phase 1
   always_comb begin
      phase_d = step ? phase_q + 2'd1 : (phase_q == 2'd3) ? 2'd1 : phase_q;
      err_d   = err_q | (busy & (y_in != phase_q[0]));
   end

   // state and datapath registers, async active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NREQ - 1);
         win_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         phase_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         phase_q <= phase_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_step_rr_sched.sv
// tb_step_rr_sched: scoreboard bench for step_rr_sched driving a behavioural stepped machine
module tb_step_rr_sched;
   localparam int NREQ = 4, LENW = 4;
   typedef struct {logic [NREQ-1:0] oh; int n;} exp_t;
   logic                 clk = 1'b0, reset = 1'b0, force_y0 = 1'b0, y_in;
   logic [NREQ-1:0]      req = '0, grant, done;
   logic [NREQ*LENW-1:0] len_in = '0;
   logic                 step, busy, err;
   logic [1:0]           phase, m_ph;
   exp_t                 sb[$];
   exp_t                 e;
   int                   ncmp = 0, nerr = 0, nstep = 0, k = 0;
   int                   ord[5];
   int                   s1_step[8]  = '{0, 1, 0, 1, 0, 1, 0, 0};
   int                   s1_grant[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
   int                   s1_done[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
   int                   s1_phase[8] = '{0, 0, 1, 1, 2, 2, 3, 1};

   step_rr_sched #(.NREQ(NREQ), .LENW(LENW), .GAP(1)) dut (
      .clk(clk), .reset(reset), .req(req), .len_in(len_in), .y_in(y_in),
      .grant(grant), .step(step), .busy(busy), .done(done), .phase(phase), .err(err)
   );

   always #5 clk = ~clk;

   // behavioural 4-phase machine stepped by the scheduler
   always @(posedge clk or negedge reset) begin
      if (!reset) m_ph <= 2'd0;
      else m_ph <= step ? m_ph + 2'd1 : (m_ph == 2'd3) ? 2'd1 : m_ph;
   end
   assign y_in = force_y0 ? 1'b0 : m_ph[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1 chk("rst_async", {grant, step, busy, done, phase, err}, 0);
      tick();
      tick();
      reset = 1'b1;
   endtask

   // scoreboard: every done pulse pops one expected burst
   always @(negedge clk) begin
      if (!reset) nstep = 0;
      else begin
         if (step) nstep++;
         if (done != '0) begin
            if (sb.size() == 0) chk("sb_unexpected_done", done, 0);
            else begin
               e = sb.pop_front();
               chk("done_owner", done, e.oh);
               chk("done_steps", nstep, e.n);
            end
            chk("done_grant", done & ~grant, 0);
            chk("grant_onehot", $onehot(grant), 1);
            nstep = 0;
         end
      end
   end

   initial begin
      ord = '{0, 1, 2, 3, 0};
`ifdef STEP_RR_PRIO0_EN
      ord = '{0, 0, 0, 0, 0};
`endif
      #3 chk("rst_state", {grant, step, busy, done, phase, err}, 0);
      tick();
      tick();
      reset = 1'b1;
      len_in[0 +: 4] = 4'd3;
      req = 4'b0001;
      sb.push_back(exp_t'{4'b0001, 3});
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 0) req = '0;
         chk("s1_step", step, s1_step[c]);
         chk("s1_grant", grant, s1_grant[c]);
         chk("s1_busy", busy, s1_grant[c]);
         chk("s1_done", done, s1_done[c]);
         chk("s1_phase", phase, s1_phase[c]);
      end
      chk("s1_err", err, 0);
      do_reset();
      len_in = {4{4'd1}};
      req = 4'hF;
      for (int i = 0; i < 5; i++) sb.push_back(exp_t'{NREQ'(1 << ord[i]), 1});
      for (int c = 0; c < 19; c++) begin
         tick();
         chk("rr_grant", grant, (c % 4 == 3) ? 0 : 1 << ord[c / 4]);
      end
      req = '0;
      tick();
      tick();
      chk("rr_idle", grant, 0);
      len_in[8 +: 4] = 4'd0;
      req = 4'b0100;
      sb.push_back(exp_t'{4'b0100, 0});
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 0) req = '0;
         chk("z_grant", grant, (c < 2) ? 4'b0100 : 4'b0000);
         chk("z_done", done, (c == 1) ? 4'b0100 : 4'b0000);
         chk("z_step", step, 0);
         chk("z_phase", phase, 1);
      end
      len_in[4 +: 4] = 4'd5;
      req = 4'b0010;
      sb.push_back(exp_t'{4'b0010, 5});
      k = 0;
      for (int c = 0; c < 40 && done == '0; c++) begin
         tick();
         if (step) k++;
         if (k == 2) req = '0;
      end
      chk("hold_done", done, 4'b0010);
      chk("hold_steps", k, 5);
      tick();
      chk("hold_release", grant, 0);
      req = 4'b0010;
      for (int c = 0; c < 10 && !step; c++) tick();
      chk("abort_step", step, 1);
      #2 reset = 1'b0;
      #1 chk("rst_mid", {grant, step, busy, done, phase, err}, 0);
      req = '0;
      tick();
      chk("abort_nodone", done, 0);
      tick();
      reset = 1'b1;
      len_in[0 +: 4] = 4'd3;
      req = 4'b0001;
      sb.push_back(exp_t'{4'b0001, 3});
      tick();
      req = '0;
      tick();
      tick();
      chk("err_clean", err, 0);
      chk("err_ph", phase, 1);
      force_y0 = 1'b1;
      tick();
      force_y0 = 1'b0;
      chk("err_set", err, 1);
      for (int c = 0; c < 20 && done == '0; c++) tick();
      chk("err_done", done, 4'b0001);
      tick();
      tick();
      chk("err_sticky", err, 1);
      do_reset();
      chk("err_clr", err, 0);
`ifdef STEP_RR_PRIO0_EN
      len_in = {4{4'd1}};
      req = 4'b0011;
      for (int i = 0; i < 3; i++) sb.push_back(exp_t'{4'b0001, 1});
      k = 0;
      for (int c = 0; c < 60 && k < 4; c++) begin
         tick();
         if (done != '0) begin
            k++;
            chk("prio_owner", done, (k <= 3) ? 4'b0001 : 4'b0010);
            if (k == 3) begin
               req = 4'b0010;
               sb.push_back(exp_t'{4'b0010, 1});
            end
            if (k == 4) req = '0;
         end
      end
      chk("prio_count", k, 4);
`endif
      tick();
      tick();
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
